// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master native memory bus arbiter.
//   arb_state_t : arbiter ownership state (IDLE, GNT0, GNT1)
//   DEF_TIMEOUT : default number of granted cycles before forced completion
//   ERR_RDATA   : read data returned to a master whose transaction timed out
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_TIMEOUT = 255;
  localparam int unsigned ERR_RDATA   = 0;

endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// Stall counter for a granted transaction.
//   clk, reset : clock, synchronous active-high reset
//   clear      : hold the count at zero (asserted while no transaction is owned)
//   enable     : count one stalled granted cycle
//   expire     : count has reached TIMEOUT-1, i.e. this is the last allowed cycle
module arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expire = (cnt == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one PicoRV32-native memory bus between the core
// (master 0) and a loader/debug master (master 1). One whole transaction is
// granted at a time; a transaction stalled for TIMEOUT cycles is completed
// to its master with zero read data and a one-cycle timeout_err pulse.
//   clk, reset              : clock, synchronous active-high reset
//   m0_* / m1_*             : master request (valid/addr/wdata/wstrb) and
//                             response (ready/rdata)
//   s_*                     : slave request and response
//   grant                   : one-hot current owner, 0 when idle
//   timeout_err             : pulses on forced completion
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_valid,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  output logic                  m0_ready,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_valid,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic                  m1_ready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  s_valid,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_ready,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            grant,
  output logic                  timeout_err
);

  arb_state_t state, state_nxt;
  // last: master that most recently completed (0 = m0, 1 = m1)
  logic last, last_nxt;
  logic tmo_clear, tmo_en, tmo_expire;

  // Owner-side view of the request, so both grant states share one path.
  logic                own;
  logic                own_valid;
  logic                own_ready;
  logic                own_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  assign tmo_clear = (state == IDLE);

  arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expire (tmo_expire)
  );

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    tmo_en      = 1'b0;
    own         = (state == GNT1);
    own_valid   = 1'b0;
    own_ready   = 1'b0;
    own_err     = 1'b0;
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    grant       = 2'b00;

    unique case (state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_nxt = last ? GNT0 : GNT1;
        end else if (m0_valid) begin
          state_nxt = GNT0;
        end else if (m1_valid) begin
          state_nxt = GNT1;
        end
      end
      GNT0, GNT1: begin
        grant     = own ? 2'b10 : 2'b01;
        own_valid = own ? m1_valid : m0_valid;
        s_addr    = own ? m1_addr  : m0_addr;
        s_wdata   = own ? m1_wdata : m0_wdata;
        s_wstrb   = own ? m1_wstrb : m0_wstrb;
        // A dropped request is abandoned silently; it does not count as
        // served, so the round-robin pointer is left alone.
        if (!own_valid) begin
          state_nxt = IDLE;
        end else if (s_ready) begin
          s_valid   = 1'b1;
          own_ready = 1'b1;
          state_nxt = IDLE;
          last_nxt  = own;
        end else if (tmo_expire) begin
          own_ready = 1'b1;
          own_err   = 1'b1;
          state_nxt = IDLE;
          last_nxt  = own;
        end else begin
          s_valid = 1'b1;
          tmo_en  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m0_ready    = own_ready && !own;
    m1_ready    = own_ready &&  own;
    timeout_err = own_err;
    m0_rdata    = (own_err && !own) ? DATA_W'(ERR_RDATA) : s_rdata;
    m1_rdata    = (own_err &&  own) ? DATA_W'(ERR_RDATA) : s_rdata;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: inputs are always changed just after a falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = '0;
    m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [1:0]  g;
    logic        sv;
    logic [31:0] sa, sw;
    logic [3:0]  ss;
    logic        r0, r1, err;
    logic [31:0] rd0, rd1;
  } out_t;

  int mdl_owner;   // -1: bus free, else index of owning master
  int mdl_wait;    // granted cycles already spent without completion
  int mdl_last;    // master that most recently completed

  task automatic mdl_reset();
    mdl_owner = -1; mdl_wait = 0; mdl_last = 1;
  endtask

  task automatic mdl_outputs(output out_t e);
    logic v;
    e = '{g: 2'b00, sv: 0, sa: '0, sw: '0, ss: '0, r0: 0, r1: 0, err: 0,
          rd0: s_rdata, rd1: s_rdata};
    if (mdl_owner >= 0) begin
      v    = (mdl_owner == 0) ? m0_valid : m1_valid;
      e.g  = (mdl_owner == 0) ? 2'b01 : 2'b10;
      e.sa = (mdl_owner == 0) ? m0_addr  : m1_addr;
      e.sw = (mdl_owner == 0) ? m0_wdata : m1_wdata;
      e.ss = (mdl_owner == 0) ? m0_wstrb : m1_wstrb;
      if (v && s_ready) begin
        e.sv = 1;
        if (mdl_owner == 0) e.r0 = 1; else e.r1 = 1;
      end else if (v && mdl_wait == TMO - 1) begin
        e.err = 1;
        if (mdl_owner == 0) begin e.r0 = 1; e.rd0 = '0; end
        else begin e.r1 = 1; e.rd1 = '0; end
      end else if (v) begin
        e.sv = 1;
      end
    end
  endtask

  task automatic mdl_step();
    logic v;
    if (reset) begin
      mdl_reset();
    end else if (mdl_owner < 0) begin
      mdl_wait = 0;
      if (m0_valid && m1_valid) mdl_owner = 1 - mdl_last;
      else if (m0_valid)        mdl_owner = 0;
      else if (m1_valid)        mdl_owner = 1;
    end else begin
      v = (mdl_owner == 0) ? m0_valid : m1_valid;
      if (!v) begin
        mdl_owner = -1;
      end else if (s_ready || mdl_wait == TMO - 1) begin
        mdl_last  = mdl_owner;
        mdl_owner = -1;
      end else begin
        mdl_wait++;
      end
    end
  endtask

  task automatic cmp_all(input out_t e);
    chk("grant",       64'(grant),       64'(e.g));
    chk("s_valid",     64'(s_valid),     64'(e.sv));
    chk("s_addr",      64'(s_addr),      64'(e.sa));
    chk("s_wdata",     64'(s_wdata),     64'(e.sw));
    chk("s_wstrb",     64'(s_wstrb),     64'(e.ss));
    chk("m0_ready",    64'(m0_ready),    64'(e.r0));
    chk("m1_ready",    64'(m1_ready),    64'(e.r1));
    chk("timeout_err", 64'(timeout_err), 64'(e.err));
    chk("m0_rdata",    64'(m0_rdata),    64'(e.rd0));
    chk("m1_rdata",    64'(m1_rdata),    64'(e.rd1));
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
    mdl_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          m0v, m1v, sr;
    logic [31:0] rd;
    logic [1:0]  g;
    bit          sv, r0, r1;
    logic [31:0] rd0, addr;
  } vec_t;

  vec_t tbl[12];

  logic [1:0]  mv;
  logic [31:0] ma[2], mw[2];
  logic [3:0]  ms[2];

  initial begin
    out_t e;
    int t;
    reset = 1;
    idle_inputs();
    #1;
    tick();
    tick();
    // reset state, inputs idle, reset still asserted
    chk("rst_grant",  64'(grant), 64'd0);
    chk("rst_svalid", 64'(s_valid), 64'd0);
    chk("rst_saddr",  64'({s_addr, s_wdata}), 64'd0);
    chk("rst_swstrb", 64'(s_wstrb), 64'd0);
    chk("rst_ready",  64'({m0_ready, m1_ready}), 64'd0);
    chk("rst_err",    64'(timeout_err), 64'd0);
    reset = 0;
    mdl_reset();

    // single read by m0 then alternating contention (m0 addr 4, m1 LED)
    tbl[0]  = '{1, 0, 0, 32'h0,   2'b00, 0, 0, 0, 32'h0,   32'h0};
    tbl[1]  = '{1, 0, 0, 32'h0,   2'b01, 1, 0, 0, 32'h0,   32'h4};
    tbl[2]  = '{1, 0, 1, 32'h113, 2'b01, 1, 1, 0, 32'h113, 32'h4};
    tbl[3]  = '{0, 0, 0, 32'h0,   2'b00, 0, 0, 0, 32'h0,   32'h0};
    tbl[4]  = '{1, 1, 0, 32'h0,   2'b00, 0, 0, 0, 32'h0,   32'h0};
    tbl[5]  = '{1, 1, 1, 32'hAA,  2'b10, 1, 0, 1, 32'hAA,  32'h1000_0000};
    tbl[6]  = '{1, 1, 1, 32'hBB,  2'b00, 0, 0, 0, 32'hBB,  32'h0};
    tbl[7]  = '{1, 1, 0, 32'h0,   2'b01, 1, 0, 0, 32'h0,   32'h4};
    tbl[8]  = '{1, 1, 1, 32'hCC,  2'b01, 1, 1, 0, 32'hCC,  32'h4};
    tbl[9]  = '{1, 1, 0, 32'h0,   2'b00, 0, 0, 0, 32'h0,   32'h0};
    tbl[10] = '{1, 1, 1, 32'hDD,  2'b10, 1, 0, 1, 32'hDD,  32'h1000_0000};
    tbl[11] = '{0, 0, 0, 32'h0,   2'b00, 0, 0, 0, 32'h0,   32'h0};

    m0_addr = 32'h4; m0_wstrb = 4'h0;
    m1_addr = 32'h1000_0000; m1_wdata = 32'h1; m1_wstrb = 4'hF;
    for (int i = 0; i < 12; i++) begin
      m0_valid = tbl[i].m0v; m1_valid = tbl[i].m1v;
      s_ready  = tbl[i].sr;  s_rdata  = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_grant", i), 64'(grant),    64'(tbl[i].g));
      chk($sformatf("tbl%0d_sval", i),  64'(s_valid),  64'(tbl[i].sv));
      chk($sformatf("tbl%0d_rdy0", i),  64'(m0_ready), 64'(tbl[i].r0));
      chk($sformatf("tbl%0d_rdy1", i),  64'(m1_ready), 64'(tbl[i].r1));
      chk($sformatf("tbl%0d_rd0", i),   64'(m0_rdata), 64'(tbl[i].rd0));
      chk($sformatf("tbl%0d_addr", i),  64'(s_addr),   64'(tbl[i].addr));
      tick();
    end

    // LED write by m1
    do_reset();
    m1_valid = 1; m1_addr = 32'h1000_0000; m1_wdata = 32'h1; m1_wstrb = 4'hF;
    #1;
    tick();
    s_ready = 1;
    #1;
    chk("led_grant", 64'(grant), 64'h2);
    chk("led_addr",  64'(s_addr), 64'h1000_0000);
    chk("led_wdata", 64'(s_wdata), 64'h1);
    chk("led_wstrb", 64'(s_wstrb), 64'hF);
    chk("led_ready", 64'({m1_ready, m0_ready}), 64'h2);
    tick();
    m1_valid = 0; s_ready = 0;
    #1;
    chk("led_idle", 64'({grant, s_valid}), 64'h0);

    // timeout: slave never ready, 8th granted cycle force-completes
    do_reset();
    m0_valid = 1; m0_addr = 32'h4; s_rdata = 32'hDEAD;
    #1;
    tick();
    for (int c = 1; c <= TMO; c++) begin
      if (c < TMO) begin
        chk($sformatf("tmo_wait%0d", c), 64'({s_valid, m0_ready, timeout_err}), 64'h4);
      end else begin
        chk("tmo_fire",   64'({s_valid, m0_ready, timeout_err}), 64'h3);
        chk("tmo_rdata0", 64'(m0_rdata), 64'h0);
        chk("tmo_rdata1", 64'(m1_rdata), 64'hDEAD);
      end
      tick();
    end
    m0_valid = 0;
    #1;
    chk("tmo_after", 64'({grant, s_valid, timeout_err}), 64'h0);

    // reset during GNT1 before slave ready; m0 wins the first tie afterwards
    do_reset();
    m1_valid = 1;
    #1;
    tick();
    chk("rmid_gnt1", 64'(grant), 64'h2);
    reset = 1;
    tick();
    chk("rmid_grant", 64'({grant, s_valid}), 64'h0);
    reset = 0;
    m0_valid = 1;
    #1;
    tick();
    chk("rmid_tie", 64'(grant), 64'h1);

    // m0 drops valid mid-transaction
    do_reset();
    m0_valid = 1;
    #1;
    tick();
    m0_valid = 0;
    #1;
    chk("drop_sval", 64'({grant, s_valid, m0_ready, timeout_err}), 64'h8);
    tick();
    chk("drop_idle", 64'({grant, s_valid, m0_ready, timeout_err}), 64'h0);

    // randomized traffic against the reference model
    do_reset();
    mv = '0;
    for (int i = 0; i < 2; i++) begin
      ma[i] = '0; mw[i] = '0; ms[i] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      m0_valid = mv[0]; m0_addr = ma[0]; m0_wdata = mw[0]; m0_wstrb = ms[0];
      m1_valid = mv[1]; m1_addr = ma[1]; m1_wdata = mw[1]; m1_wstrb = ms[1];
      s_ready  = ($urandom_range(0, 9) < 3);
      s_rdata  = $urandom;
      reset    = ($urandom_range(0, 199) == 0);
      #1;
      mdl_outputs(e);
      cmp_all(e);
      t = mdl_owner;
      mdl_step();
      for (int x = 0; x < 2; x++) begin
        if ((x == 0) ? e.r0 : e.r1) begin
          mv[x] = 1'($urandom_range(0, 1));
          ma[x] = $urandom; mw[x] = $urandom; ms[x] = 4'($urandom);
        end else if (!mv[x] && $urandom_range(0, 3) == 0) begin
          mv[x] = 1;
          ma[x] = $urandom; mw[x] = $urandom; ms[x] = 4'($urandom);
        end else if (mv[x] && t == x && $urandom_range(0, 49) == 0) begin
          mv[x] = 0;
        end
      end
      tick();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
